// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the lap stopwatch and its BCD counter chain.
package stopwatch_pkg;

  typedef enum logic {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } sw_state_e;

  localparam logic [3:0]  BCD_MAX = 4'd9;
  localparam int unsigned BCD_W   = 4;

endpackage

// File: rtl/bcd_counter_chain.sv
// Multi-digit BCD up-counter; carry ripples through every digit in one cycle.
module bcd_counter_chain
  import stopwatch_pkg::*;
#(
  parameter int unsigned DIGITS = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clr_i,
  input  logic                      inc_i,
  output logic [BCD_W*DIGITS-1:0]   value_o,
  output logic                      wrap_c_o
);

  logic [BCD_W*DIGITS-1:0] value_q;
  logic [BCD_W*DIGITS-1:0] value_d;
  logic                    carry;

  // Carry survives past the top digit only when every digit was 9.
  always_comb begin
    value_d = value_q;
    carry   = inc_i;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (value_q[i*BCD_W +: BCD_W] == BCD_MAX) begin
          value_d[i*BCD_W +: BCD_W] = '0;
        end else begin
          value_d[i*BCD_W +: BCD_W] = value_q[i*BCD_W +: BCD_W] + BCD_W'(1);
          carry = 1'b0;
        end
      end
    end
    wrap_c_o = carry;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/lap_stopwatch.sv
// Decimal stopwatch with run/pause control, prescaled tick, lap memory and
// a browsable lap readout.
module lap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned LAPS     = 4,
  parameter int unsigned TICK_DIV = 5000000,
  parameter int unsigned LAP_MODE = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_stop_i,
  input  logic                         lap_i,
  input  logic                         clear_i,
  input  logic                         browse_i,
  output logic                         running_o,
  output logic [4*DIGITS-1:0]          time_bcd_o,
  output logic [4*DIGITS-1:0]          lap_bcd_o,
  output logic [$clog2(LAPS)-1:0]      lap_idx_o,
  output logic [$clog2(LAPS+1)-1:0]    lap_count_o,
  output logic                         lap_full_o,
  output logic                         overflow_o
);

  localparam int unsigned TW    = BCD_W * DIGITS;
  localparam int unsigned IDX_W = $clog2(LAPS);
  localparam int unsigned CNT_W = $clog2(LAPS + 1);
  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  sw_state_e         state_q;
  logic [PRE_W-1:0]  pre_q;
  logic              overflow_q;
  logic [TW-1:0]     slots_q [LAPS];
  logic [CNT_W-1:0]  lap_count_q;
  logic              lap_full_q;
  logic [IDX_W-1:0]  wr_ptr_q;
  logic [IDX_W-1:0]  lap_idx_q;
  logic [TW-1:0]     time_q;
  logic              tick_c;
  logic              wrap_c;

  assign tick_c = (state_q == RUN) && (pre_q == PRE_W'(TICK_DIV - 1));

  bcd_counter_chain #(.DIGITS(DIGITS)) u_chain (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (clear_i),
    .inc_i    (tick_c),
    .value_o  (time_q),
    .wrap_c_o (wrap_c)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q     <= PAUSE;
      pre_q       <= '0;
      overflow_q  <= 1'b0;
      lap_count_q <= '0;
      lap_full_q  <= 1'b0;
      wr_ptr_q    <= '0;
      lap_idx_q   <= '0;
      for (int unsigned i = 0; i < LAPS; i++) slots_q[i] <= '0;
    end else begin
      if (start_stop_i) state_q <= (state_q == RUN) ? PAUSE : RUN;

      // Prescaler freezes in PAUSE so a partial tick survives a pause.
      if (state_q == RUN) pre_q <= tick_c ? '0 : pre_q + PRE_W'(1);

      if (wrap_c) overflow_q <= 1'b1;

      if (lap_i && state_q == RUN) begin
        if (LAP_MODE != 0 || lap_count_q < CNT_W'(LAPS)) begin
          slots_q[wr_ptr_q] <= time_q;
          wr_ptr_q <= (wr_ptr_q == IDX_W'(LAPS - 1)) ? '0 : wr_ptr_q + IDX_W'(1);
          if (lap_count_q < CNT_W'(LAPS)) begin
            lap_count_q <= lap_count_q + CNT_W'(1);
            lap_full_q  <= (lap_count_q == CNT_W'(LAPS - 1));
          end
        end
      end

      // A lap pulse in PAUSE wipes the memory and overrides any browse.
      if (lap_i && state_q == PAUSE) begin
        lap_count_q <= '0;
        lap_full_q  <= 1'b0;
        wr_ptr_q    <= '0;
        lap_idx_q   <= '0;
        for (int unsigned i = 0; i < LAPS; i++) slots_q[i] <= '0;
      end else if (browse_i) begin
        if (lap_count_q == '0) begin
          lap_idx_q <= '0;
        end else if (lap_idx_q == IDX_W'(lap_count_q - CNT_W'(1))) begin
          lap_idx_q <= '0;
        end else begin
          lap_idx_q <= lap_idx_q + IDX_W'(1);
        end
      end
    end
  end

  assign running_o   = (state_q == RUN);
  assign time_bcd_o  = time_q;
  assign lap_bcd_o   = (lap_count_q == '0) ? '0 : slots_q[lap_idx_q];
  assign lap_idx_o   = lap_idx_q;
  assign lap_count_o = lap_count_q;
  assign lap_full_o  = lap_full_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Self-checking bench: two stopwatch instances (stop-when-full and ring lap
// modes) sharing stimulus, checked against an integer reference model.
module tb_lap_stopwatch;

  localparam int TICK = 4;

  logic clk = 1'b0;
  logic rst_i = 1'b0, start_stop_i = 1'b0, lap_i = 1'b0, clear_i = 1'b0, browse_i = 1'b0;

  logic        run0, run1, full0, full1, ovf0, ovf1;
  logic [11:0] time0, time1, bcd0, bcd1;
  logic [1:0]  idx0, idx1;
  logic [2:0]  cnt0, cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lap_stopwatch #(.DIGITS(3), .LAPS(4), .TICK_DIV(TICK), .LAP_MODE(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst_i), .start_stop_i(start_stop_i), .lap_i(lap_i),
    .clear_i(clear_i), .browse_i(browse_i), .running_o(run0), .time_bcd_o(time0),
    .lap_bcd_o(bcd0), .lap_idx_o(idx0), .lap_count_o(cnt0), .lap_full_o(full0),
    .overflow_o(ovf0));

  lap_stopwatch #(.DIGITS(3), .LAPS(4), .TICK_DIV(TICK), .LAP_MODE(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_i), .start_stop_i(start_stop_i), .lap_i(lap_i),
    .clear_i(clear_i), .browse_i(browse_i), .running_o(run1), .time_bcd_o(time1),
    .lap_bcd_o(bcd1), .lap_idx_o(idx1), .lap_count_o(cnt1), .lap_full_o(full1),
    .overflow_o(ovf1));

  // Reference model: time as a plain integer, laps as write counts into arrays.
  int m_run, m_pre, m_time, m_ovf;
  int m_slot [2][4];
  int m_nw [2];
  int m_idx [2];

  function automatic int to_bcd(input int v);
    return (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  function automatic int mcnt(input int m);
    return (m_nw[m] > 4) ? 4 : m_nw[m];
  endfunction

  function automatic int mlap(input int m);
    return (mcnt(m) == 0) ? 0 : to_bcd(m_slot[m][m_idx[m]]);
  endfunction

  task automatic model_step(input logic ss, lp, cl, br, rs);
    int tick, old_cnt;
    if (rs || cl) begin
      m_run = 0; m_pre = 0; m_time = 0; m_ovf = 0;
      for (int m = 0; m < 2; m++) begin
        m_nw[m] = 0; m_idx[m] = 0;
        for (int s = 0; s < 4; s++) m_slot[m][s] = 0;
      end
    end else begin
      tick = (m_run != 0 && m_pre == TICK - 1) ? 1 : 0;
      if (m_run != 0) m_pre = (tick != 0) ? 0 : m_pre + 1;
      for (int m = 0; m < 2; m++) begin
        old_cnt = mcnt(m);
        if (lp && m_run != 0) begin
          if (!(m == 0 && m_nw[m] >= 4)) begin
            m_slot[m][m_nw[m] % 4] = m_time;
            m_nw[m] = m_nw[m] + 1;
          end
        end else if (lp) begin
          m_nw[m] = 0; m_idx[m] = 0;
          for (int s = 0; s < 4; s++) m_slot[m][s] = 0;
        end
        if (br && !(lp && m_run == 0))
          m_idx[m] = (old_cnt == 0) ? 0 : (m_idx[m] + 1) % old_cnt;
      end
      if (tick != 0) begin
        if (m_time == 999) begin m_time = 0; m_ovf = 1; end
        else m_time = m_time + 1;
      end
      if (ss) m_run = (m_run != 0) ? 0 : 1;
    end
  endtask

  task automatic check(input string name, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("m_time0", time0, to_bcd(m_time));
    check("m_time1", time1, to_bcd(m_time));
    check("m_run0", run0, m_run);
    check("m_run1", run1, m_run);
    check("m_ovf0", ovf0, m_ovf);
    check("m_ovf1", ovf1, m_ovf);
    check("m_cnt0", cnt0, mcnt(0));
    check("m_cnt1", cnt1, mcnt(1));
    check("m_full0", full0, (mcnt(0) == 4) ? 1 : 0);
    check("m_full1", full1, (mcnt(1) == 4) ? 1 : 0);
    check("m_idx0", idx0, m_idx[0]);
    check("m_idx1", idx1, m_idx[1]);
    check("m_lap0", bcd0, mlap(0));
    check("m_lap1", bcd1, mlap(1));
  endtask

  task automatic cycle(input logic ss, lp, cl, br);
    start_stop_i = ss; lap_i = lp; clear_i = cl; browse_i = br;
    @(posedge clk);
    model_step(ss, lp, cl, br, rst_i);
    #1;
    start_stop_i = 1'b0; lap_i = 1'b0; clear_i = 1'b0; browse_i = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic until_time(input int t);
    int budget = 5000;
    while (m_time != t && budget > 0) begin
      idle(1);
      budget--;
    end
    check("until_time_budget", (m_time == t) ? 1 : 0, 1);
  endtask

  typedef struct {
    int          till;
    logic        ss, lp, br;
    logic [11:0] e_bcd0, e_bcd1;
    int          e_cnt0, e_cnt1, e_idx;
  } vec_t;

  vec_t vec [9];
  int   t_hold;

  initial begin
    vec[0] = '{3,  1'b0, 1'b1, 1'b0, 12'h003, 12'h003, 1, 1, 0};
    vec[1] = '{5,  1'b0, 1'b1, 1'b0, 12'h003, 12'h003, 2, 2, 0};
    vec[2] = '{7,  1'b0, 1'b1, 1'b0, 12'h003, 12'h003, 3, 3, 0};
    vec[3] = '{9,  1'b0, 1'b1, 1'b0, 12'h003, 12'h003, 4, 4, 0};
    vec[4] = '{11, 1'b0, 1'b1, 1'b0, 12'h003, 12'h011, 4, 4, 0};
    vec[5] = '{-1, 1'b0, 1'b0, 1'b1, 12'h005, 12'h005, 4, 4, 1};
    vec[6] = '{-1, 1'b0, 1'b0, 1'b1, 12'h007, 12'h007, 4, 4, 2};
    vec[7] = '{-1, 1'b0, 1'b0, 1'b1, 12'h009, 12'h009, 4, 4, 3};
    vec[8] = '{-1, 1'b0, 1'b0, 1'b1, 12'h003, 12'h011, 4, 4, 0};

    // Reset
    rst_i = 1'b1;
    idle(2);
    rst_i = 1'b0;
    check("rst_time", time0, 12'h000);
    check("rst_run", run0, 0);
    check("rst_cnt", cnt0, 0);
    check("rst_ovf", ovf0, 0);
    check("rst_idx", idx1, 0);

    // 40 RUN cycles = 10 ticks
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(40);
    check("run40_time", time0, 12'h010);
    check("run40_run", run0, 1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("stop_time", time0, 12'h010);
    check("stop_run", run0, 0);

    // Pause with prescaler at 2, resume: tick lands 2 RUN cycles later
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    check("pause_hold", time0, 12'h000);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    check("resume_1", time0, 12'h000);
    idle(1);
    check("resume_2", time0, 12'h001);

    // Overflow
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3996);
    check("at999_time", time0, 12'h999);
    check("at999_ovf", ovf0, 0);
    idle(4);
    check("wrap_time", time1, 12'h000);
    check("wrap_ovf", ovf1, 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("clr_ovf", ovf1, 0);

    // Lap table
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      if (vec[i].till >= 0) until_time(vec[i].till);
      cycle(vec[i].ss, vec[i].lp, 1'b0, vec[i].br);
      check("tbl_bcd0", bcd0, vec[i].e_bcd0);
      check("tbl_bcd1", bcd1, vec[i].e_bcd1);
      check("tbl_cnt0", cnt0, vec[i].e_cnt0);
      check("tbl_cnt1", cnt1, vec[i].e_cnt1);
      check("tbl_idx0", idx0, vec[i].e_idx);
      check("tbl_idx1", idx1, vec[i].e_idx);
    end
    check("tbl_full0", full0, 1);

    // Lap in PAUSE clears laps only
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    t_hold = to_bcd(m_time);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("pclr_cnt1", cnt1, 0);
    check("pclr_bcd1", bcd1, 12'h000);
    check("pclr_full0", full0, 0);
    check("pclr_time", time1, t_hold);

    // Same-cycle tick and lap at 0x005
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    idle(23);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("tlap_bcd", bcd0, 12'h005);
    check("tlap_time", time0, 12'h006);

    // Clear wins over start_stop
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check("clrss_run", run0, 0);
    check("clrss_time", time0, 12'h000);
    check("clrss_cnt", cnt1, 0);

    // Random pulses against the model
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(39) == 0), ($urandom_range(7) == 0),
            ($urandom_range(499) == 0), ($urandom_range(5) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
